// File: rtl/rsbus_d2r_arbiter_if.sv
// rsbus_d2r_arbiter_if
// Bundles the requester-side and injector-side signals of the d2r arbiter.
//   req_i_stb  : per-requester "complete frame ready"
//   req_i_len  : per-requester frame length select, 0=short, 1=long
//   req_i_bus  : per-requester current word
//   req_o_rd   : per-requester word-consume strobe
//   frm_o_stb  : frame word valid toward the injector
//   frm_o_sof  : first (header) word of a frame
//   frm_o_iid  : injector id of the granted requester
//   frm_o_bus  : frame word
//   frm_i_af   : injector almost-full, [0] short, [1] long
// master modport: the arbiter. slave modport: requesters plus injector.
interface rsbus_d2r_arbiter_if #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned WORD_W = 32
);
    logic [N_REQ-1:0]             req_i_stb;
    logic [N_REQ-1:0]             req_i_len;
    logic [N_REQ-1:0][WORD_W-1:0] req_i_bus;
    logic [N_REQ-1:0]             req_o_rd;
    logic                         frm_o_stb;
    logic                         frm_o_sof;
    logic [3:0]                   frm_o_iid;
    logic [WORD_W-1:0]            frm_o_bus;
    logic [1:0]                   frm_i_af;

    modport master (
        input  req_i_stb, req_i_len, req_i_bus, frm_i_af,
        output req_o_rd, frm_o_stb, frm_o_sof, frm_o_iid, frm_o_bus
    );

    modport slave (
        output req_i_stb, req_i_len, req_i_bus, frm_i_af,
        input  req_o_rd, frm_o_stb, frm_o_sof, frm_o_iid, frm_o_bus
    );
endinterface

// File: rtl/rsbus_d2r_arbiter.sv
// rsbus_d2r_arbiter
// Frame-level round-robin arbiter sharing one ring-injection port between
// N_REQ local devices. One eligible requester is granted per frame and its
// words are streamed, contiguously, onto the frm_o_* port.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous reset, active-high
//   bus  : rsbus_d2r_arbiter_if.master (requester inputs, req_o_rd,
//          frame stream outputs, injector almost-full flags)
//
// state | meaning
// IDLE  | pick the next eligible requester starting from ptr
// XFER  | stream the granted frame, one word per cycle
module rsbus_d2r_arbiter #(
    parameter int unsigned N_REQ       = 4,
    parameter logic [3:0]  BASE_ID     = 4'd0,
    parameter int unsigned SHORT_WORDS = 2,
    parameter int unsigned LONG_WORDS  = 10,
    parameter int unsigned WORD_W      = 32
) (
    input  logic                clk,
    input  logic                rst,
    rsbus_d2r_arbiter_if.master bus
);
    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(LONG_WORDS);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [PTR_W-1:0]  sel_q, sel_d;
    logic              len_q, len_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              stb_q, stb_d;
    logic              sof_q, sof_d;
    logic [3:0]        iid_q, iid_d;
    logic [WORD_W-1:0] word_q, word_d;

    logic [N_REQ-1:0]  elig;
    logic [N_REQ-1:0]  rd;
    logic [WORD_W-1:0] sel_word;
    logic [CNT_W-1:0]  cnt_last;
    logic              found;
    logic [PTR_W-1:0]  gnt_sel;
    logic [PTR_W-1:0]  gnt_nxt;
    logic              gnt_len;

    always_comb begin
        elig = '0;
        for (int i = 0; i < N_REQ; i++) begin
            elig[i] = bus.req_i_stb[i] && !bus.frm_i_af[bus.req_i_len[i]];
        end
    end

    // Rotating priority as two passes: first the indices at or above ptr,
    // then wrap around to the ones below it.
    always_comb begin
        found   = 1'b0;
        gnt_sel = '0;
        gnt_nxt = '0;
        gnt_len = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && elig[i] && (i >= int'(ptr_q))) begin
                found   = 1'b1;
                gnt_sel = PTR_W'(i);
                gnt_nxt = PTR_W'((i + 1) % N_REQ);
                gnt_len = bus.req_i_len[i];
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && elig[i]) begin
                found   = 1'b1;
                gnt_sel = PTR_W'(i);
                gnt_nxt = PTR_W'((i + 1) % N_REQ);
                gnt_len = bus.req_i_len[i];
            end
        end
    end

    always_comb begin
        sel_word = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (sel_q == PTR_W'(i)) begin
                sel_word = bus.req_i_bus[i];
            end
        end
    end

    assign cnt_last = len_q ? CNT_W'(LONG_WORDS - 1) : CNT_W'(SHORT_WORDS - 1);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        stb_d   = 1'b0;
        sof_d   = 1'b0;
        iid_d   = iid_q;
        word_d  = word_q;
        rd      = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    sel_d   = gnt_sel;
                    len_d   = gnt_len;
                    cnt_d   = '0;
                    ptr_d   = gnt_nxt;
                    state_d = XFER;
                end
            end
            XFER: begin
                for (int i = 0; i < N_REQ; i++) begin
                    rd[i] = (sel_q == PTR_W'(i));
                end
                stb_d  = 1'b1;
                sof_d  = (cnt_q == '0);
                word_d = sel_word;
                iid_d  = BASE_ID + 4'(sel_q);
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == cnt_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            len_q   <= 1'b0;
            cnt_q   <= '0;
            stb_q   <= 1'b0;
            sof_q   <= 1'b0;
            iid_q   <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            stb_q   <= stb_d;
            sof_q   <= sof_d;
            iid_q   <= iid_d;
            word_q  <= word_d;
        end
    end

    // Requesters share rst, so the consume strobe is held low while it is asserted.
    assign bus.req_o_rd  = rst ? '0 : rd;
    assign bus.frm_o_stb = stb_q;
    assign bus.frm_o_sof = sof_q;
    assign bus.frm_o_iid = iid_q;
    assign bus.frm_o_bus = word_q;
endmodule

// File: tb/tb_rsbus_d2r_arbiter.sv
// Bench for rsbus_d2r_arbiter: a 4-requester instance (BASE_ID=4) and a
// single-requester instance (BASE_ID=7) driven by behavioural requesters.
module tb_rsbus_d2r_arbiter;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rsbus_d2r_arbiter_if #(.N_REQ(4), .WORD_W(W)) if0 ();
    rsbus_d2r_arbiter_if #(.N_REQ(1), .WORD_W(W)) if1 ();

    rsbus_d2r_arbiter #(.N_REQ(4), .BASE_ID(4'd4), .SHORT_WORDS(2), .LONG_WORDS(10), .WORD_W(W))
        dut0 (.clk(clk), .rst(rst), .bus(if0));
    rsbus_d2r_arbiter #(.N_REQ(1), .BASE_ID(4'd7), .SHORT_WORDS(2), .LONG_WORDS(10), .WORD_W(W))
        dut1 (.clk(clk), .rst(rst), .bus(if1));

    // requesters 0..3 feed dut0, requester 4 feeds dut1
    logic [4:0]   stb_all = '0;
    logic [4:0]   len_all = '0;
    logic [W-1:0] bus_all [5];
    logic [1:0]   af_v    [2];
    logic [4:0]   rd_all;
    logic [4:0]   rd_s;

    assign if0.req_i_stb = stb_all[3:0];
    assign if0.req_i_len = len_all[3:0];
    assign if0.req_i_bus = {bus_all[3], bus_all[2], bus_all[1], bus_all[0]};
    assign if0.frm_i_af  = af_v[0];
    assign if1.req_i_stb = stb_all[4];
    assign if1.req_i_len = len_all[4];
    assign if1.req_i_bus = bus_all[4];
    assign if1.frm_i_af  = af_v[1];
    assign rd_all = {if1.req_o_rd, if0.req_o_rd};

    logic         o_stb [2];
    logic         o_sof [2];
    logic [3:0]   o_iid [2];
    logic [W-1:0] o_bus [2];
    assign o_stb[0] = if0.frm_o_stb;
    assign o_sof[0] = if0.frm_o_sof;
    assign o_iid[0] = if0.frm_o_iid;
    assign o_bus[0] = if0.frm_o_bus;
    assign o_stb[1] = if1.frm_o_stb;
    assign o_sof[1] = if1.frm_o_sof;
    assign o_iid[1] = if1.frm_o_iid;
    assign o_bus[1] = if1.frm_o_bus;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // requester state and spawn controls
    bit         has  [5];
    bit         flen [5];
    int         seq  [5];
    int         off  [5];
    int         lsel [5];
    logic [4:0] spawn_mask = '0;
    int         spawn_pct  = 100;
    bit         rand_af    = 1'b0;

    // reference model: arbiter free time, rotation pointer, consume window
    typedef struct {
        int           cyc;
        logic         sof;
        logic [3:0]   iid;
        logic [W-1:0] w;
    } exp_t;
    exp_t sbq [2][$];
    int   m_ptr [2];
    int   m_free [2];
    int   m_rd_from [2];
    int   m_rd_to [2];
    int   m_sel [2];
    bit   flush = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [W-1:0] word_of(input int i, input int s, input int k);
        return {4'(i), 4'(s), 8'(k), 16'(s * 37 + k * 11 + i * 5)};
    endfunction

    function automatic int nreq(input int d);  return (d != 0) ? 1 : 4;  endfunction
    function automatic int lo_of(input int d); return (d != 0) ? 4 : 0;  endfunction
    function automatic int base(input int d);  return (d != 0) ? 7 : 4;  endfunction

    task automatic model_step(input int d);
        int t, n, nw;
        logic [3:0] exp_rd, act_rd;
        exp_t e;
        t = cyc;
        n = nreq(d);
        exp_rd = '0;
        if (!rst && t >= m_rd_from[d] && t <= m_rd_to[d]) exp_rd[m_sel[d]] = 1'b1;
        act_rd = (d == 0) ? rd_s[3:0] : {3'b000, rd_s[4]};
        chk($sformatf("d%0d_req_o_rd", d), 64'(act_rd), 64'(exp_rd));
        if (rst) begin
            m_ptr[d] = 0; m_free[d] = t + 1; m_rd_to[d] = -1; flush = 1'b1;
            return;
        end
        if (t < m_free[d]) return;
        for (int k = 0; k < n; k++) begin
            int r, g;
            r = (m_ptr[d] + k) % n;
            g = lo_of(d) + r;
            if (stb_all[g] && !af_v[d][len_all[g]]) begin
                nw = len_all[g] ? 10 : 2;
                for (int j = 0; j < nw; j++) begin
                    e.cyc = t + 2 + j;
                    e.sof = (j == 0);
                    e.iid = 4'(base(d) + r);
                    e.w   = word_of(g, seq[g], j);
                    sbq[d].push_back(e);
                end
                m_free[d]    = t + nw + 1;
                m_rd_from[d] = t + 1;
                m_rd_to[d]   = t + nw;
                m_sel[d]     = r;
                m_ptr[d]     = (r + 1) % n;
                break;
            end
        end
    endtask

    // one clock: sample at negedge, model + requester update, drive after posedge
    task automatic cycle1();
        @(negedge clk);
        rd_s = rd_all;
        model_step(0);
        model_step(1);
        for (int i = 0; i < 5; i++) begin
            if (rst) begin
                has[i] = 1'b0; off[i] = 0;
            end else if (rd_s[i]) begin
                off[i]++;
                if (off[i] == (flen[i] ? 10 : 2)) begin
                    has[i] = 1'b0; off[i] = 0;
                end
            end
        end
        @(posedge clk);
        #1;
        if (flush) begin
            sbq[0].delete(); sbq[1].delete(); flush = 1'b0;
        end
        for (int i = 0; i < 5; i++) begin
            if (!has[i] && spawn_mask[i] && int'($urandom_range(99)) < spawn_pct) begin
                has[i]  = 1'b1;
                seq[i]  = seq[i] + 1;
                off[i]  = 0;
                flen[i] = (lsel[i] == 2) ? 1'($urandom_range(1)) : 1'(lsel[i]);
            end
            stb_all[i] = has[i];
            len_all[i] = flen[i];
            bus_all[i] = has[i] ? word_of(i, seq[i], off[i]) : $urandom;
        end
        if (rand_af) begin
            if ($urandom_range(7) == 0) af_v[0] = 2'($urandom_range(3));
            if ($urandom_range(7) == 0) af_v[1] = 2'($urandom_range(3));
        end
    endtask

    task automatic step(input int n);
        repeat (n) cycle1();
    endtask

    task automatic wait_grant(input int d);
        int k = 0;
        while (!(m_free[d] > cyc) && k < 60) begin
            cycle1(); k++;
        end
        chk($sformatf("d%0d_grant_wait", d), 64'(k < 60), 64'd1);
    endtask

    task automatic drain();
        int k = 0;
        spawn_mask = '0;
        rand_af    = 1'b0;
        af_v[0]    = 2'b00;
        af_v[1]    = 2'b00;
        while ((sbq[0].size() != 0 || sbq[1].size() != 0 || m_free[0] > cyc ||
                m_free[1] > cyc || has[0] || has[1] || has[2] || has[3] || has[4]) && k < 400) begin
            cycle1(); k++;
        end
        chk("drain_done", 64'(k < 400), 64'd1);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (o_stb[d]) begin
                if (sbq[d].size() == 0) begin
                    chk($sformatf("d%0d_unexpected_word", d), 64'(o_stb[d]), 64'd0);
                end else begin
                    e = sbq[d].pop_front();
                    chk($sformatf("d%0d_word_cycle", d), 64'(cyc), 64'(e.cyc));
                    chk($sformatf("d%0d_sof", d), 64'(o_sof[d]), 64'(e.sof));
                    chk($sformatf("d%0d_iid", d), 64'(o_iid[d]), 64'(e.iid));
                    chk($sformatf("d%0d_bus", d), 64'(o_bus[d]), 64'(e.w));
                end
            end else begin
                chk($sformatf("d%0d_sof_idle", d), 64'(o_sof[d]), 64'd0);
            end
        end
    end

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        for (int i = 0; i < 5; i++) begin
            has[i] = 1'b0; flen[i] = 1'b0; seq[i] = 0; off[i] = 0; lsel[i] = 0;
            bus_all[i] = '0;
        end
        for (int d = 0; d < 2; d++) begin
            m_ptr[d] = 0; m_free[d] = 0; m_rd_from[d] = 0; m_rd_to[d] = -1; m_sel[d] = 0;
            af_v[d] = 2'b00;
        end

        // reset values
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d_rst_stb", d), 64'(o_stb[d]), 64'd0);
            chk($sformatf("d%0d_rst_sof", d), 64'(o_sof[d]), 64'd0);
            chk($sformatf("d%0d_rst_iid", d), 64'(o_iid[d]), 64'd0);
            chk($sformatf("d%0d_rst_bus", d), 64'(o_bus[d]), 64'd0);
        end
        chk("rst_rd", 64'(rd_all), 64'd0);

        // single short frame from requester 1
        spawn_mask = 5'b00010; lsel[1] = 0; spawn_pct = 100;
        step(1);
        spawn_mask = '0;
        step(8);
        drain();

        // all short and held; single-requester instance runs back-to-back long frames
        for (int i = 0; i < 4; i++) lsel[i] = 0;
        lsel[4] = 1;
        spawn_mask = 5'b11111;
        step(45);
        drain();

        // long blocked by af[1], short keeps flowing, then long released
        af_v[0] = 2'b10; lsel[0] = 1; lsel[2] = 0;
        spawn_mask = 5'b00101;
        step(20);
        af_v[0] = 2'b00;
        step(30);
        drain();

        // af[1] raised mid long frame: frame completes, next long waits
        lsel[0] = 1; spawn_mask = 5'b00001;
        wait_grant(0);
        step(3);
        af_v[0] = 2'b10;
        step(25);
        af_v[0] = 2'b00;
        step(20);
        drain();

        // reset mid long frame, then req0 + req3 together
        lsel[0] = 1; lsel[3] = 0; spawn_mask = 5'b00001;
        wait_grant(0);
        step(5);
        spawn_mask = 5'b01001;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("midrst_stb", 64'(o_stb[0]), 64'd0);
        chk("midrst_rd", 64'(rd_all), 64'd0);
        step(30);
        drain();

        // randomized traffic and af activity
        rand_af = 1'b1;
        for (int r = 0; r < 40; r++) begin
            spawn_mask = 5'($urandom_range(31));
            spawn_pct  = int'($urandom_range(100, 10));
            for (int i = 0; i < 5; i++) lsel[i] = int'($urandom_range(2));
            step(40);
        end
        drain();
        chk("sb0_empty", 64'(sbq[0].size()), 64'd0);
        chk("sb1_empty", 64'(sbq[1].size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
